// File: rtl/board_ram_arbiter.sv
// Board RAM arbiter: shares the single-port board RAM between game requesters
// with round-robin grants, a hold lock and read data tagged to the issuer.
module board_ram_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 6,
  parameter int RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic [NUM_REQ-1:0]        wren,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_in,
  output logic                      ram_wren,
  input  logic [DATA_W-1:0]         ram_q,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_OWNED = 1'b1} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [RD_LAT-1:0]  r_pipe_vld;
  logic [IDX_W-1:0]   r_pipe_idx [RD_LAT];

  logic               w_active;
  logic               w_rd_issue;
  logic               w_hold;
  logic [NUM_REQ-1:0] w_others;
  logic [IDX_W-1:0]   w_next;
  logic [IDX_W-1:0]   w_pick_idle;
  logic [IDX_W-1:0]   w_pick_rel;

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? IDX_W'(0) : IDX_W'(int'(idx) + 1);
  endfunction

  // Scan downwards so the requester closest to start (modulo NUM_REQ) wins.
  function automatic logic [IDX_W-1:0] f_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] sel;
    int               idx;
    sel = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NUM_REQ;
      if (v[idx]) sel = IDX_W'(idx);
    end
    return sel;
  endfunction

  // Owner-selected RAM access path and arbitration candidates.
  always_comb begin
    w_active    = (r_state == S_OWNED);
    w_hold      = req[r_owner] | lock[r_owner];
    w_others    = req & ~f_onehot(r_owner);
    w_next      = f_next(r_owner);
    w_pick_idle = f_pick(req, r_ptr);
    w_pick_rel  = f_pick(w_others, w_next);
    ram_addr    = {ADDR_W{1'b0}};
    ram_in      = {DATA_W{1'b0}};
    ram_wren    = 1'b0;
    w_rd_issue  = 1'b0;
    if (w_active) begin
      ram_addr   = addr[r_owner*ADDR_W +: ADDR_W];
      ram_in     = wdata[r_owner*DATA_W +: DATA_W];
      ram_wren   = req[r_owner] & wren[r_owner];
      w_rd_issue = req[r_owner] & ~wren[r_owner];
    end else begin
      ram_addr   = {ADDR_W{1'b0}};
      ram_in     = {DATA_W{1'b0}};
      ram_wren   = 1'b0;
      w_rd_issue = 1'b0;
    end
  end

  // Grant FSM: round-robin from idle, hold while req|lock, re-arbitrate on release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_owner <= {IDX_W{1'b0}};
      r_ptr   <= {IDX_W{1'b0}};
      r_gnt   <= {NUM_REQ{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_state <= S_OWNED;
            r_owner <= w_pick_idle;
            r_gnt   <= f_onehot(w_pick_idle);
          end else begin
            r_gnt   <= {NUM_REQ{1'b0}};
          end
        end
        S_OWNED: begin
          if (w_hold) begin
            r_gnt <= f_onehot(r_owner);
          end else begin
            r_ptr <= w_next;
            // Direct handoff avoids an idle bubble when someone else waits.
            if (|w_others) begin
              r_owner <= w_pick_rel;
              r_gnt   <= f_onehot(w_pick_rel);
            end else begin
              r_state <= S_IDLE;
              r_gnt   <= {NUM_REQ{1'b0}};
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

  // Read-return pipeline matching the RAM latency, tagged with the issuer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pipe_vld <= {RD_LAT{1'b0}};
      for (int k = 0; k < RD_LAT; k++) r_pipe_idx[k] <= {IDX_W{1'b0}};
    end else begin
      for (int k = RD_LAT - 1; k > 0; k--) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        r_pipe_idx[k] <= r_pipe_idx[k-1];
      end
      r_pipe_vld[0] <= w_rd_issue;
      r_pipe_idx[0] <= r_owner;
    end
  end

  // Decode the pipeline tail into the per-requester read-valid pulse.
  always_comb begin
    rvalid = {NUM_REQ{1'b0}};
    if (r_pipe_vld[RD_LAT-1]) begin
      rvalid = f_onehot(r_pipe_idx[RD_LAT-1]);
    end else begin
      rvalid = {NUM_REQ{1'b0}};
    end
  end

  assign gnt   = r_gnt;
  assign rdata = ram_q;
  assign busy  = (|r_gnt) | (|r_pipe_vld);

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter with a 2-cycle-latency RAM model.
module tb_board_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req, lock, wren;
  logic [7:0]  addr_a [4];
  logic [5:0]  wdata_a [4];
  logic [31:0] addr_flat;
  logic [23:0] wdata_flat;
  logic [3:0]  gnt, rvalid;
  logic [5:0]  rdata, ram_in, ram_q;
  logic [7:0]  ram_addr;
  logic        ram_wren, busy;

  logic [5:0]  mem [256];
  logic [255:0] written;
  logic [5:0]  s1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign addr_flat  = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
  assign wdata_flat = {wdata_a[3], wdata_a[2], wdata_a[1], wdata_a[0]};

  board_ram_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(6), .RD_LAT(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .addr(addr_flat),
    .wdata(wdata_flat), .wren(wren), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_in(ram_in), .ram_wren(ram_wren), .ram_q(ram_q),
    .busy(busy)
  );

  // Unwritten locations read back as addr[5:0] ^ 6'h3F.
  function automatic logic [5:0] model_rd(input logic [7:0] a);
    logic [5:0] dflt;
    dflt = a[5:0] ^ 6'h3F;
    return written[a] ? mem[a] : dflt;
  endfunction

  // RAM model: synchronous write, two-cycle registered read.
  always @(posedge clk) begin
    if (!reset_n) written <= '0;
    else if (ram_wren) begin
      mem[ram_addr]     <= ram_in;
      written[ram_addr] <= 1'b1;
    end
    s1    <= model_rd(ram_addr);
    ram_q <= s1;
  end

  task automatic clear_inputs();
    req = 4'b0000; lock = 4'b0000; wren = 4'b0000;
    for (int i = 0; i < 4; i++) begin addr_a[i] = 8'h00; wdata_a[i] = 6'h00; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1; reset_n = 1'b0; clear_inputs();
    @(posedge clk); #1; reset_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear_inputs(); req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt c%0d: got %b want 0000", c, gnt); end
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid c%0d: got %b want 0000", c, rvalid); end
      checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren c%0d: got %b want 0", c, ram_wren); end
      if (c < 2) next_cycle();
    end
    next_cycle(); reset_n = 1'b1;
    next_cycle(); @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_release_gnt: got %b want 0001", gnt); end
  endtask

  task automatic test_single_read();
    do_reset();
    req = 4'b0100; addr_a[2] = 8'h15;
    next_cycle(); @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL sr_gnt: got %b want 0100", gnt); end
    checks++; if (ram_addr !== 8'h15) begin errors++; $display("FAIL sr_addr: got %h want 15", ram_addr); end
    next_cycle(); req = 4'b0000; @(negedge clk);
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL sr_rvalid_early: got %b want 0000", rvalid); end
    next_cycle(); @(negedge clk);
    checks++; if (rvalid !== 4'b0100) begin errors++; $display("FAIL sr_rvalid: got %b want 0100", rvalid); end
    checks++; if (rdata !== 6'h2A) begin errors++; $display("FAIL sr_rdata: got %h want 2a", rdata); end
    next_cycle(); @(negedge clk);
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL sr_rvalid_late: got %b want 0000", rvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sr_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_rr [13];
    logic [3:0] want;
    exp_rr = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 13; k++) begin
      next_cycle();
      want = 4'b0001 << exp_rr[k];
      req  = ((k % 3) == 2) ? (4'b1111 & ~want) : 4'b1111;
      @(negedge clk);
      checks++; if (gnt !== want) begin errors++; $display("FAIL rr_gnt k%0d: got %b want %b", k, gnt, want); end
    end
    next_cycle(); req = 4'b0000;
  endtask

  task automatic test_lock_burst();
    do_reset();
    req = 4'b1010; lock = 4'b0010; addr_a[1] = 8'h20;
    next_cycle(); @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL lk_gnt0: got %b want 0010", gnt); end
    checks++; if (ram_addr !== 8'h20) begin errors++; $display("FAIL lk_addr0: got %h want 20", ram_addr); end
    next_cycle(); req = 4'b1000; @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL lk_gnt1: got %b want 0010", gnt); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL lk_wren1: got %b want 0", ram_wren); end
    next_cycle(); @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL lk_gnt2: got %b want 0010", gnt); end
    checks++; if (rvalid !== 4'b0010) begin errors++; $display("FAIL lk_rvalid: got %b want 0010", rvalid); end
    checks++; if (rdata !== 6'h1F) begin errors++; $display("FAIL lk_rdata: got %h want 1f", rdata); end
    next_cycle(); req = 4'b1010; wren[1] = 1'b1; addr_a[1] = 8'h30; wdata_a[1] = 6'h07; @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL lk_gnt3: got %b want 0010", gnt); end
    checks++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL lk_wren3: got %b want 1", ram_wren); end
    checks++; if (ram_addr !== 8'h30 || ram_in !== 6'h07) begin errors++; $display("FAIL lk_wr_bus: got %h/%h want 30/07", ram_addr, ram_in); end
    next_cycle(); req = 4'b1000; lock = 4'b0000; wren[1] = 1'b0; @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL lk_gnt4: got %b want 0010", gnt); end
    next_cycle(); @(negedge clk);
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL lk_handoff: got %b want 1000", gnt); end
    checks++; if (model_rd(8'h30) !== 6'h07) begin errors++; $display("FAIL lk_mem30: got %h want 07", model_rd(8'h30)); end
    next_cycle(); req = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [3:0] want_g [5];
    logic [3:0] want_v [5];
    logic [5:0] want_d [5];
    want_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
    want_v = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    want_d = '{6'h00, 6'h00, 6'h3F, 6'h3E, 6'h00};
    do_reset();
    req = 4'b0011; wren = 4'b0010; addr_a[0] = 8'h00; addr_a[1] = 8'h40; wdata_a[1] = 6'h3F;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      if (k == 1) addr_a[0] = 8'h01;
      if (k == 2) req = 4'b0010;
      if (k == 4) req = 4'b0000;
      @(negedge clk);
      checks++; if (gnt !== want_g[k]) begin errors++; $display("FAIL ho_gnt k%0d: got %b want %b", k, gnt, want_g[k]); end
      checks++; if (rvalid !== want_v[k]) begin errors++; $display("FAIL ho_rvalid k%0d: got %b want %b", k, rvalid, want_v[k]); end
      if (want_v[k][0]) begin
        checks++; if (rdata !== want_d[k]) begin errors++; $display("FAIL ho_rdata k%0d: got %h want %h", k, rdata, want_d[k]); end
      end
    end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL ho_wren_idle: got %b want 0", ram_wren); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0100; addr_a[2] = 8'h15;
    next_cycle(); @(negedge clk);
    checks++; if (gnt !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL mr_issue: got gnt=%b busy=%b want 0100/1", gnt, busy); end
    next_cycle(); reset_n = 1'b0; req = 4'b0000; @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mr_inflight_busy: got %b want 1", busy); end
    next_cycle(); reset_n = 1'b1; @(negedge clk);
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL mr_after: got gnt=%b busy=%b want 0000/0", gnt, busy); end
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL mr_rvalid2: got %b want 0000", rvalid); end
    next_cycle(); @(negedge clk);
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL mr_rvalid3: got %b want 0000", rvalid); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock_burst();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
